// File: rtl/video_timing_gen_if.sv
// Pixel read channel between the timing generator (master) and the upstream
// frame/pattern source (slave). The slave must return i_data one cycle after rd_req.
interface video_timing_gen_if;
    logic        rd_req;
    logic [11:0] rd_x;
    logic [11:0] rd_y;
    logic [23:0] i_data;

    modport master (output rd_req, output rd_x, output rd_y, input i_data);
    modport slave  (input rd_req, input rd_x, input rd_y, output i_data);
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator with per-pixel upstream read and 2-stage re-alignment.
// Define VIDEO_TIMING_GEN_PATTERN_EN to replace i_data with an internal 8-bar colour pattern.
module video_timing_gen #(
    parameter int   H_ACTIVE = 1280,
    parameter int   H_FP     = 110,
    parameter int   H_SYNC   = 40,
    parameter int   H_BP     = 220,
    parameter int   V_ACTIVE = 720,
    parameter int   V_FP     = 5,
    parameter int   V_SYNC   = 5,
    parameter int   V_BP     = 20,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_en,
    video_timing_gen_if.master        rd_bus,
    output logic                      o_hs,
    output logic                      o_vs,
    output logic                      o_de,
    output logic [23:0]               o_data,
    output logic [11:0]               x,
    output logic [11:0]               y,
    output logic                      o_sof
);

    localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int PIPE_DEPTH = 2;

    // 13-bit constants so a 4096-wide total still compares correctly against 12-bit counters.
    localparam logic [12:0] H_ACT_C   = 13'(H_ACTIVE);
    localparam logic [12:0] H_SYNC_S  = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] H_SYNC_E  = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] H_LAST_C  = 13'(H_TOTAL - 1);
    localparam logic [12:0] V_ACT_C   = 13'(V_ACTIVE);
    localparam logic [12:0] V_SYNC_S  = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] V_SYNC_E  = 13'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [12:0] V_LAST_C  = 13'(V_TOTAL - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic        sof;
        logic [11:0] x;
        logic [11:0] y;
    } tap_t;

    state_t      state_q, state_d;
    logic [11:0] h_cnt_q, h_cnt_d;
    logic [11:0] v_cnt_q, v_cnt_d;
    logic        counting;
    logic        h_last, v_last, frame_end;
    logic        active_st;
    logic        raw_de, raw_hs, raw_vs, raw_sof;
    tap_t        tap_s0;
    tap_t        tap_q [PIPE_DEPTH];
    logic [23:0] data_q, data_d;

    assign h_last    = ({1'b0, h_cnt_q} == H_LAST_C);
    assign v_last    = ({1'b0, v_cnt_q} == V_LAST_C);
    assign frame_end = h_last && v_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Dropping i_en only ever finishes the frame in flight; IDLE is entered at the frame wrap.
    always_comb begin
        state_d  = state_q;
        h_cnt_d  = h_cnt_q;
        v_cnt_d  = v_cnt_q;
        counting = 1'b0;
        case (state_q)
            IDLE: begin
                h_cnt_d = '0;
                v_cnt_d = '0;
                if (i_en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                counting = 1'b1;
                if (!i_en) begin
                    state_d = frame_end ? IDLE : STOPPING;
                end
            end
            STOPPING: begin
                counting = 1'b1;
                if (i_en) begin
                    state_d = RUN;
                end else if (frame_end) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                h_cnt_d = '0;
                v_cnt_d = '0;
            end
        endcase
        if (counting) begin
            if (h_last) begin
                h_cnt_d = '0;
                v_cnt_d = v_last ? 12'd0 : v_cnt_q + 12'd1;
            end else begin
                h_cnt_d = h_cnt_q + 12'd1;
            end
        end
    end

    assign active_st = (state_q != IDLE);
    assign raw_de    = active_st && ({1'b0, h_cnt_q} < H_ACT_C) && ({1'b0, v_cnt_q} < V_ACT_C);
    assign raw_hs    = active_st && ({1'b0, h_cnt_q} >= H_SYNC_S) && ({1'b0, h_cnt_q} < H_SYNC_E);
    assign raw_vs    = active_st && ({1'b0, v_cnt_q} >= V_SYNC_S) && ({1'b0, v_cnt_q} < V_SYNC_E);
    assign raw_sof   = active_st && (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);

    assign rd_bus.rd_req = raw_de;
    assign rd_bus.rd_x   = raw_de ? h_cnt_q : 12'd0;
    assign rd_bus.rd_y   = raw_de ? v_cnt_q : 12'd0;

    always_comb begin
        tap_s0     = '0;
        tap_s0.hs  = raw_hs;
        tap_s0.vs  = raw_vs;
        tap_s0.de  = raw_de;
        tap_s0.sof = raw_sof;
        tap_s0.x   = rd_bus.rd_x;
        tap_s0.y   = rd_bus.rd_y;
    end

    genvar gi;
    generate
        for (gi = 0; gi < PIPE_DEPTH; gi++) begin : g_pipe
            tap_t tap_in;
            if (gi == 0) begin : g_head
                assign tap_in = tap_s0;
            end else begin : g_tail
                assign tap_in = tap_q[gi-1];
            end
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    tap_q[gi] <= '0;
                end else begin
                    tap_q[gi] <= tap_in;
                end
            end
        end
    endgenerate

`ifdef VIDEO_TIMING_GEN_PATTERN_EN
    logic [31:0] bar_idx;
    logic        unused_i_data;

    // Colour is picked from the stage-1 column so it lands beside the same x at the output.
    assign bar_idx       = {17'd0, tap_q[0].x, 3'b000} / 32'(H_ACTIVE);
    assign unused_i_data = ^rd_bus.i_data;

    always_comb begin
        data_d = 24'h000000;
        case (bar_idx)
            32'd0:   data_d = 24'hFFFFFF;
            32'd1:   data_d = 24'hFFFF00;
            32'd2:   data_d = 24'h00FFFF;
            32'd3:   data_d = 24'h00FF00;
            32'd4:   data_d = 24'hFF00FF;
            32'd5:   data_d = 24'hFF0000;
            32'd6:   data_d = 24'h0000FF;
            default: data_d = 24'h000000;
        endcase
    end
`else
    assign data_d = rd_bus.i_data;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign o_hs   = tap_q[PIPE_DEPTH-1].hs ? HS_POL : ~HS_POL;
    assign o_vs   = tap_q[PIPE_DEPTH-1].vs ? VS_POL : ~VS_POL;
    assign o_de   = tap_q[PIPE_DEPTH-1].de;
    assign o_sof  = tap_q[PIPE_DEPTH-1].sof;
    assign x      = tap_q[PIPE_DEPTH-1].x;
    assign y      = tap_q[PIPE_DEPTH-1].y;
    assign o_data = o_de ? data_q : 24'd0;

endmodule
